ex_div: RTL
===========

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; result width is 2*DATA_W.
REQ-002 SHALL have port cpu_clk_75M  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port div_start  input  1  EX requests a divide (DIV/DIVU aluop in EX).
REQ-005 SHALL have port signed_div  input  1  1 = signed DIV, 0 = unsigned DIVU.
REQ-006 SHALL have port div_opdata1  input  DATA_W  dividend (EX reg1).
REQ-007 SHALL have port div_opdata2  input  DATA_W  divisor (EX reg2).
REQ-008 SHALL have port annul  input  1  pipeline flush; cancels any operation in progress.
REQ-009 SHALL have port div_result  output  2*DATA_W  {remainder, quotient}, i.e. {HI, LO}.
REQ-010 SHALL have port div_ready  output  1  div_result valid this cycle.
REQ-011 SHALL have port stallreq_div  output  1  request to stall the pipeline up to and including EX.

Function
REQ-012 SHALL implement FSM states FREE, BYZERO, ON, END, plus a 6-bit iteration counter cnt and a 2*DATA_W+1 bit working register.
REQ-013 FREE: div_start=1 and annul=0 and divisor==0 -> BYZERO; divisor!=0 -> ON, latching |dividend| and |divisor| (unsigned: raw values), the operand signs and signed_div; cnt cleared to 0.
REQ-014 FREE with div_start=0 or annul=1 SHALL stay FREE.
REQ-015 ON: each edge performs one restoring shift-subtract step and increments cnt; the edge on which cnt==DATA_W-1 completes the last step and moves to END.
REQ-016 Transition into END SHALL register div_result: quotient negated if signed_div and operand signs differ; remainder negated if signed_div and dividend negative.
REQ-017 BYZERO: next edge -> END with div_result = 0.
REQ-018 ON or BYZERO with annul=1 SHALL return to FREE on the next edge; div_ready SHALL NOT assert for the cancelled operation.
REQ-019 END: div_ready=1, div_result held; div_start=0 or annul=1 -> FREE, otherwise stay END.
REQ-020 Leaving END for FREE SHALL clear div_result to 0; div_ready=0 in all states except END.
REQ-021 Latency: div_ready SHALL first be high after exactly DATA_W+1 edges from the edge sampling div_start in FREE (33 for DATA_W=32), or 2 edges for divisor 0.
REQ-022 stallreq_div SHALL equal div_start & ~div_ready & ~annul, combinational.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, no exception.
REQ-024 Changes to div_opdata1/2 or signed_div while in ON, BYZERO or END SHALL have no effect on the operation in progress.

Reset
REQ-025 cpu_rst=1 SHALL immediately force state FREE, cnt=0, working register 0, div_result=0, div_ready=0, regardless of clock.
REQ-026 Reset asserted during ON SHALL abort the operation; after release, the block SHALL accept a new div_start from FREE.

Verification
REQ-027 Unsigned 100/7, div_start held high -> stallreq_div high 33 cycles, then div_ready=1, div_result={0x00000002,0x0000000E}, stallreq_div=0.
REQ-028 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> div_result={0xFFFFFFFF,0xFFFFFFFD} after 33 edges.
REQ-029 Divisor 0, any dividend -> div_ready at edge 2, div_result=0; div_start dropped -> FREE next edge.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> div_result={0x00000000,0x80000000}; unsigned same operands -> {0x80000000,0x00000000}.
REQ-031 annul pulsed at cnt=10 -> FREE next edge, div_ready never asserts; a new 9/3 start then yields {0,3} after 33 edges.
REQ-032 cpu_rst pulsed mid-ON, asynchronously between edges -> outputs 0 immediately; subsequent 20/6 unsigned yields {2,3}.

Source files
------------

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle restoring divider for the EX stage (DIV/DIVU), {remainder, quotient} result
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic                  cpu_clk_75M,
  input  logic                  cpu_rst,
  input  logic                  div_start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     div_opdata1,
  input  logic [DATA_W-1:0]     div_opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   div_result,
  output logic                  div_ready,
  output logic                  stallreq_div
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t              state;
  logic [5:0]          cnt;
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   divisor;
  logic                neg_quo;
  logic                neg_rem;

  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W:0]   work_step;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign op1_abs = (signed_div && div_opdata1[DATA_W-1]) ? (~div_opdata1 + 1'b1) : div_opdata1;
  assign op2_abs = (signed_div && div_opdata2[DATA_W-1]) ? (~div_opdata2 + 1'b1) : div_opdata2;

  // Upper half holds the partial remainder, lower half collects quotient bits as the dividend shifts out.
  assign diff      = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
  assign work_step = diff[DATA_W] ? {work[2*DATA_W-1:0], 1'b0}
                                  : {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
  assign quo       = work_step[DATA_W-1:0];
  assign rem       = work_step[2*DATA_W:DATA_W+1];
  assign quo_fix   = neg_quo ? (~quo + 1'b1) : quo;
  assign rem_fix   = neg_rem ? (~rem + 1'b1) : rem;

  assign stallreq_div = div_start & ~div_ready & ~annul;

  always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= FREE;
      cnt        <= 6'd0;
      work       <= '0;
      divisor    <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      div_result <= '0;
      div_ready  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (div_start && !annul) begin
            if (div_opdata2 == '0) begin
              state <= BYZERO;
            end else begin
              state   <= ON;
              cnt     <= 6'd0;
              work    <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
              divisor <= op2_abs;
              neg_quo <= signed_div & (div_opdata1[DATA_W-1] ^ div_opdata2[DATA_W-1]);
              neg_rem <= signed_div & div_opdata1[DATA_W-1];
            end
          end
        end
        BYZERO: begin
          if (annul) begin
            state <= FREE;
          end else begin
            state      <= END;
            div_result <= '0;
            div_ready  <= 1'b1;
          end
        end
        ON: begin
          if (annul) begin
            state <= FREE;
            cnt   <= 6'd0;
          end else begin
            work <= work_step;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'(DATA_W - 1)) begin
              state      <= END;
              div_result <= {rem_fix, quo_fix};
              div_ready  <= 1'b1;
            end
          end
        end
        END: begin
          if (!div_start || annul) begin
            state      <= FREE;
            div_result <= '0;
            div_ready  <= 1'b0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule
